// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  localparam int unsigned RD_LAT_MAX = 7;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  // Request payload captured from the winning port
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/unified_mem_arbiter_grant_select.sv
// Combinational grant selection between the instruction and data ports.
// Optional macro: ARB_ROUND_ROBIN_EN (alternate on contention, else data wins).
// Ports:
//   i_valid, d_valid : pending requests
//   last_grant       : owner of the previous grant (only used with round robin)
//   grant_valid      : some request is pending
//   grant_owner      : port that wins this cycle
module arb_grant_select
  import unified_mem_arbiter_pkg::*;
(
  input  logic       i_valid,
  input  logic       d_valid,
  input  arb_owner_t last_grant,
  output logic       grant_valid,
  output arb_owner_t grant_owner
);

`ifdef ARB_ROUND_ROBIN_EN
  // On contention give the port that lost last time; a lone requester always wins
  always_comb begin
    grant_valid = i_valid | d_valid;
    grant_owner = OWN_I;
    if (i_valid && d_valid) begin
      grant_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (d_valid) begin
      grant_owner = OWN_D;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = logic'(last_grant);

  // Fixed priority: data over instruction
  always_comb begin
    grant_valid = i_valid | d_valid;
    grant_owner = d_valid ? OWN_D : OWN_I;
  end
`endif

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises instruction fetches and data accesses onto one single-port
// synchronous memory with a configurable read latency.
// Optional macro: ARB_ROUND_ROBIN_EN (alternate grants on contention).
// Ports:
//   clk, reset (sync, active-low)
//   i_addr/i_valid -> i_good/i_rdata              instruction port
//   d_addr/d_valid/d_we/d_wstrb/d_wdata -> d_good/d_rdata   data port
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata   block memory
//   busy                                          arbiter not idle
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_AW = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       i_addr,
  input  logic              i_valid,
  output logic              i_good,
  output logic [31:0]       i_rdata,
  input  logic [31:0]       d_addr,
  input  logic              d_valid,
  input  logic              d_we,
  input  logic [3:0]        d_wstrb,
  input  logic [31:0]       d_wdata,
  output logic              d_good,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  arb_state_t       state, state_next;
  arb_owner_t       owner;
  arb_owner_t       last_grant;
  arb_owner_t       grant_owner;
  logic             grant_valid;
  logic             req_we;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             load;
  arb_req_t         req_next;

  arb_grant_select u_grant_select (
    .i_valid     (i_valid),
    .d_valid     (d_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who was granted last so contention alternates
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= OWN_I;
    end else if (load) begin
      last_grant <= grant_owner;
    end
  end
`else
  assign last_grant = OWN_I;
`endif

  // Next-state, counter and winner payload
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    load           = 1'b0;
    req_next.addr  = i_addr;
    req_next.we    = 1'b0;
    req_next.wstrb = 4'h0;
    req_next.wdata = 32'h0;
    if (grant_owner == OWN_D) begin
      req_next.addr  = d_addr;
      req_next.we    = d_we;
      req_next.wstrb = d_wstrb;
      req_next.wdata = d_wdata;
    end
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (req_we) begin
          state_next = DONE;
        end else begin
          cnt_next   = CNT_W'(RD_LAT);
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered memory and port outputs.
  // Memory outputs are loaded on the IDLE->ISSUE edge so they are live during ISSUE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= OWN_I;
      req_we    <= 1'b0;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_good    <= 1'b0;
      d_good    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load) begin
        owner  <= grant_owner;
        req_we <= req_next.we;
      end
      mem_en    <= load;
      mem_we    <= (load && req_next.we) ? req_next.wstrb : 4'h0;
      mem_addr  <= load ? MEM_AW'(req_next.addr >> 2) : '0;
      mem_wdata <= (load && req_next.we) ? req_next.wdata : 32'h0;
      if (state == WAIT && cnt == CNT_W'(1)) begin
        if (owner == OWN_D) d_rdata <= mem_rdata;
        else                i_rdata <= mem_rdata;
      end
      i_good <= (state_next == DONE) && (owner == OWN_I);
      d_good <= (state_next == DONE) && (owner == OWN_D);
      busy   <= (state_next != IDLE);
    end
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction port and the data port of the pipelined CPU top.
- Both ports use the codebase's valid/good handshake.
- Sits between the IMemPort/DMemPort pair and one block memory, replacing the separate instruction and data memories.
- Serialises accesses through a small FSM with a configurable memory read latency.

Parameters:
- MEM_AW, 10, memory word-address width; mem_addr = req_addr[MEM_AW+1:2].
- RD_LAT, 1, memory read latency in cycles (1..7); mem_rdata is valid RD_LAT cycles after the mem_en cycle.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- i_addr  in  32  instruction byte address.
- i_valid  in  1  instruction request.
- i_good  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  32  fetched word.
- d_addr  in  32  data byte address.
- d_valid  in  1  data request.
- d_we  in  1  1=write, 0=read.
- d_wstrb  in  4  byte write strobes; ignored on reads.
- d_wdata  in  32  write data.
- d_good  out  1  one-cycle completion pulse.
- d_rdata  out  32  read word.
- mem_en  out  1  memory enable.
- mem_we  out  4  byte write enables.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (reset==0 sampled at a rising edge):
  - state=IDLE.
  - All outputs 0: i_good, d_good, mem_en, mem_we, busy, i_rdata, d_rdata, mem_addr, mem_wdata.
  - Last-grant flag = I.
  - Reset mid-transaction aborts it: no good pulse, no write issued afterwards.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If d_valid or i_valid, latch the winner's addr/we/wstrb/wdata and grant owner, then go to ISSUE.
  - Fixed priority: data over instruction.
- ISSUE (exactly 1 cycle):
  - mem_en=1, mem_addr/mem_wdata from the latched values.
  - mem_we = wstrb if write, else 0.
  - Write goes to DONE; read loads the counter with RD_LAT and goes to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When it reaches 1, capture mem_rdata into the owner's rdata register and go to DONE.
- DONE (1 cycle):
  - Owner's good=1, then go to IDLE.
  - The non-owner's good stays 0.
  - rdata registers hold until the next read for that port.
- Latency from first valid cycle to good:
  - Read: 3+RD_LAT-1 cycles (3 for RD_LAT=1).
  - Write: 2 cycles.
- No new request is sampled in DONE.
- A requester still asserting valid after good is treated as a new request in the following IDLE cycle.
- Requester fields are sampled only in IDLE.
- Dropping valid mid-transaction does not cancel it; good still pulses.
- Writes with d_wstrb==0 still complete with d_good and produce no memory change.
- i_addr/d_addr bits [1:0] are ignored. Bits above MEM_AW+1 are ignored, so addresses wrap modulo memory size.
- busy = (state != IDLE).

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - When both valid in IDLE, grant the port that was NOT granted last.
  - The last-grant flag updates on each grant.
  - A single requester is always granted.
- Undefined: fixed data-over-instruction priority; the last-grant flag is not implemented.

Decomposition:
- Shared package holds:
  - Enum arb_state_t {IDLE, ISSUE, WAIT, DONE}.
  - Enum arb_owner_t {OWN_I, OWN_D}.
  - Constant RD_LAT_MAX=7.
  - The 3-bit counter width.
- One natural sub-module: arb_grant_select. It is combinational: inputs i_valid, d_valid, last_grant; outputs grant_valid, grant_owner. It contains the ARB_ROUND_ROBIN_EN logic.

Test Plan:
- Reset release, single i read at i_addr=0x0000_0010 with mem[4]=0x0000_0013, RD_LAT=1 -> mem_en high with mem_addr=4 one cycle after request; i_good pulses 3 cycles after i_valid; i_rdata=0x13; d_good stays 0.
- d write d_addr=0x20, d_wstrb=4'b0011, d_wdata=0xAABBCCDD -> mem_we=4'b0011 at mem_addr=8 for exactly one cycle; d_good 2 cycles after d_valid; a following read of 0x20 returns low half 0xCCDD.
- i_valid and d_valid asserted simultaneously and held (macro undefined) -> d served first, i served next; i_good follows d_good after 4 cycles; no overlap of mem_en.
- Same as above with ARB_ROUND_ROBIN_EN and both held for 4 grants -> grant order D,I,D,I.
- reset driven low during WAIT of a read, RD_LAT=4 -> next edge state IDLE, no i_good/d_good, mem_en=0, busy=0.
- RD_LAT=3, d read 0x3FFC plus address bit 14 set -> mem_addr=0x3FF (wrap); d_good 5 cycles after d_valid.
